// File: rtl/pacc_poly_reduce_pkg.sv
// Shared Kyber constants, Barrett parameters, FSM encoding and pipeline record
// used by the PAcc polynomial reduction stages.
package pacc_poly_reduce_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int BARRETT_V     = 20159;
    localparam int BARRETT_SHIFT = 26;
    localparam int BARRETT_ROUND = 1 << 25;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [7:0]         idx;
        logic signed [15:0] a;
        logic signed [31:0] prod;
    } s1_t;

endpackage

// File: rtl/pacc_poly_reduce_if.sv
// Start/done handshake and polynomial buses between the accumulator and the reducer.
interface pacc_poly_reduce_if #(
    parameter int POLY_W = 4096
);
    logic              enable;
    logic [POLY_W-1:0] iPoly;
    logic              Poly_Reduce_done;
    logic [POLY_W-1:0] oPoly;

    modport master (
        output enable,
        output iPoly,
        input  Poly_Reduce_done,
        input  oPoly
    );

    modport slave (
        input  enable,
        input  iPoly,
        output Poly_Reduce_done,
        output oPoly
    );
endinterface

// File: rtl/pacc_poly_reduce_barrett.sv
// Combinational Barrett tail: turns a coefficient and its biased product into the
// centred representative mod q. Shared with later reduce/compress stages.
module pacc_poly_reduce_barrett
    import pacc_poly_reduce_pkg::*;
#(
    parameter int Q_MOD = KYBER_Q,
    parameter int SHIFT = BARRETT_SHIFT
) (
    input  logic signed [15:0] i_a,
    input  logic signed [31:0] i_prod,
    output logic signed [15:0] o_r
);

    logic signed [31:0] w_t;

    assign w_t = i_prod >>> SHIFT;
    // Only the low 16 bits of a - t*q matter; the true result always fits.
    assign o_r = i_a - 16'(w_t * Q_MOD);

endmodule

// File: rtl/pacc_poly_reduce.sv
// Sequential Barrett reduction of a 256-coefficient polynomial, one coefficient per
// cycle through a two-stage pipeline, with a one-cycle done pulse per pass.
module pacc_poly_reduce
    import pacc_poly_reduce_pkg::ST_IDLE;
    import pacc_poly_reduce_pkg::ST_RUN;
    import pacc_poly_reduce_pkg::ST_FLUSH;
    import pacc_poly_reduce_pkg::BARRETT_V;
    import pacc_poly_reduce_pkg::BARRETT_ROUND;
    import pacc_poly_reduce_pkg::s1_t;
#(
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int COEFF_W = 16,
    parameter int POLY_W  = COEFF_W * KYBER_N
) (
    input logic               clk,
    input logic               reset_n,
    pacc_poly_reduce_if.slave bus
);

    logic [1:0]        r_state;
    logic [7:0]        r_idx;
    s1_t               r_s1;
    logic              r_done;
    logic [POLY_W-1:0] r_poly;

    logic signed [15:0] w_a;
    logic signed [31:0] w_prod;
    logic signed [15:0] w_r;
    logic               w_last;

    // Coefficient k sits at the top of the vector, so index 0 is the MSB slice.
    assign w_a    = bus.iPoly[POLY_W-1-COEFF_W*int'(r_idx) -: COEFF_W];
    assign w_prod = 32'(w_a) * BARRETT_V + BARRETT_ROUND;
    assign w_last = (r_idx == 8'(KYBER_N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_idx <= r_idx + 8'd1;
                    if (w_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= (r_state == ST_RUN);
            r_s1.idx   <= r_idx;
            r_s1.a     <= w_a;
            r_s1.prod  <= w_prod;
        end
    end

    pacc_poly_reduce_barrett #(
        .Q_MOD(KYBER_Q)
    ) u_barrett (
        .i_a   (r_s1.a),
        .i_prod(r_s1.prod),
        .o_r   (w_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
            r_poly <= '0;
        end else begin
            // The last write lands on the FLUSH edge, the same edge that raises done.
            r_done <= (r_state == ST_FLUSH);
            if (r_s1.valid) begin
                r_poly[POLY_W-1-COEFF_W*int'(r_s1.idx) -: COEFF_W] <= w_r;
            end
        end
    end

    assign bus.oPoly            = r_poly;
    assign bus.Poly_Reduce_done = r_done;

endmodule

// File: tb/tb_pacc_poly_reduce.sv
// Randomized bench for pacc_poly_reduce against a modular-arithmetic reference.
module tb_pacc_poly_reduce;

    localparam int N  = 256;
    localparam int CW = 16;
    localparam int PW = CW * N;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pacc_poly_reduce_if #(.POLY_W(PW)) bus ();

    pacc_poly_reduce #(
        .KYBER_N(N),
        .KYBER_Q(3329),
        .COEFF_W(CW),
        .POLY_W (PW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int coeffs[N];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Centred representative in [-1664, 1664]; unique since q is odd.
    function automatic int ref_red(input int a);
        int r;
        r = a % 3329;
        if (r < 0) r += 3329;
        if (r > 1664) r -= 3329;
        return r;
    endfunction

    function automatic int out_coeff(input int k);
        logic signed [CW-1:0] v;
        v = bus.oPoly[PW-1-CW*k -: CW];
        return int'(v);
    endfunction

    task automatic load_poly();
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[PW-1-CW*k -: CW] = CW'(coeffs[k]);
        bus.iPoly = p;
    endtask

    task automatic check_all(input string tag);
        int r;
        int nbad_range;
        nbad_range = 0;
        for (int k = 0; k < N; k++) begin
            r = out_coeff(k);
            if (r < -1664 || r > 1664) nbad_range++;
            chk($sformatf("%s[%0d]", tag, k), r, ref_red(coeffs[k]));
        end
        chk({tag, "_range"}, nbad_range, 0);
    endtask

    task automatic run_pass(input bit toggle, output int lat);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.Poly_Reduce_done || lat >= 400) break;
            bus.enable = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            lat++;
        end
        bus.enable = 1'b0;
    endtask

    int lat, cnt, ndone, t1, t2;
    logic [PW-1:0] saved;

    initial begin
        bus.enable = 1'b0;
        bus.iPoly  = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(bus.Poly_Reduce_done), 0);
        chk("rst_opoly_zero", int'(bus.oPoly == '0), 1);
        reset_n = 1'b1;

        // Boundary coefficients
        for (int k = 0; k < N; k++) coeffs[k] = 0;
        coeffs[0] = 3329; coeffs[1] = 1664; coeffs[2] = 1665;
        coeffs[3] = -32768; coeffs[4] = 32767; coeffs[5] = -1665;
        load_poly();
        run_pass(1'b0, lat);
        chk("bnd_latency", lat, 257);
        chk("bnd_c0", out_coeff(0), 0);
        chk("bnd_c1", out_coeff(1), 1664);
        chk("bnd_c2", out_coeff(2), -1664);
        chk("bnd_c3", out_coeff(3), 522);
        chk("bnd_c4", out_coeff(4), -523);
        chk("bnd_c5", out_coeff(5), 1664);
        check_all("bnd");
        @(posedge clk); @(negedge clk);
        chk("done_one_cycle", int'(bus.Poly_Reduce_done), 0);

        // Ordering / packing
        for (int k = 0; k < N; k++) coeffs[k] = k;
        load_poly();
        run_pass(1'b0, lat);
        chk("ord_latency", lat, 257);
        check_all("ord");
        chk("ord_lsb_slice", int'(bus.oPoly[15:0]), 255);

        // Full random, with and without enable toggling during RUN
        for (int pass = 0; pass < 3; pass++) begin
            for (int k = 0; k < N; k++) coeffs[k] = int'($signed(16'($urandom)));
            load_poly();
            run_pass(pass[0], lat);
            chk($sformatf("rnd%0d_latency", pass), lat, 257);
            check_all($sformatf("rnd%0d", pass));
        end

        // Idle hold: iPoly changes with enable low must not disturb oPoly
        saved = bus.oPoly;
        for (int k = 0; k < N; k++) coeffs[k] = int'($signed(16'($urandom)));
        load_poly();
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.Poly_Reduce_done) cnt++;
        end
        chk("idle_done_seen", cnt, 0);
        chk("idle_opoly_hold", int'(bus.oPoly == saved), 1);

        // Back-to-back with enable held through done
        for (int k = 0; k < N; k++) coeffs[k] = int'($signed(16'($urandom)));
        load_poly();
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        cnt = 0; ndone = 0; t1 = -1; t2 = -1;
        while (cnt < 1000 && ndone < 2) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (bus.Poly_Reduce_done) begin
                if (ndone == 0) t1 = cnt;
                else t2 = cnt;
                ndone++;
            end
        end
        bus.enable = 1'b0;
        chk("b2b_first_done", t1, 257);
        chk("b2b_spacing", t2 - t1, 258);
        check_all("b2b");

        // Reset in the middle of a pass
        for (int k = 0; k < N; k++) coeffs[k] = int'($signed(16'($urandom)));
        load_poly();
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        #1 bus.enable = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_opoly_zero", int'(bus.oPoly == '0), 1);
        chk("mid_rst_done", int'(bus.Poly_Reduce_done), 0);
        chk("mid_rst_state", int'(dut.r_state), 0);
        reset_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.Poly_Reduce_done || bus.oPoly != '0) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        run_pass(1'b0, lat);
        chk("post_rst_latency", lat, 257);
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
